// File: rtl/multimode_counter.sv
// Free-running sequence counter with run-time selectable mode: binary up/down, ring, Johnson, Gray.
// A terminal-count flag marks the last state of each sequence for cascading.
module multimode_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enabled,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             tc
);

   localparam logic [2:0] ModeUp      = 3'd0;
   localparam logic [2:0] ModeDown    = 3'd1;
   localparam logic [2:0] ModeRing    = 3'd2;
   localparam logic [2:0] ModeJohnson = 3'd3;
   localparam logic [2:0] ModeGray    = 3'd4;

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] Msb = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] value_q, value_d;
   logic [2:0]       mode_q, mode_d;
   logic             is_term;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reserved modes have no sequence, so entering one keeps the current value.
   function automatic logic [WIDTH-1:0] seed(input logic [2:0] m, input logic [WIDTH-1:0] lim,
                                             input logic [WIDTH-1:0] cur);
      case (m)
         ModeUp, ModeJohnson, ModeGray: return '0;
         ModeDown:                      return lim;
         ModeRing:                      return One;
         default:                       return cur;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] step(input logic [2:0] m, input logic [WIDTH-1:0] lim,
                                             input logic [WIDTH-1:0] cur);
      case (m)
         ModeUp:      return (cur >= lim) ? '0 : cur + One;
         ModeDown:    return (cur == '0 || cur > lim) ? lim : cur - One;
         ModeRing:    return {cur[WIDTH-2:0], cur[WIDTH-1]};
         ModeJohnson: return {cur[WIDTH-2:0], ~cur[WIDTH-1]};
         ModeGray:    return bin2gray(gray2bin(cur) + One);
         default:     return cur;
      endcase
   endfunction

   always_comb begin
      mode_d  = mode_q;
      value_d = value_q;
      if (mode != mode_q) begin
         mode_d  = mode;
         value_d = seed(mode, limit, value_q);
      end else if (load) begin
         case (mode_q)
            ModeUp, ModeDown:      value_d = load_value;
            ModeGray:              value_d = bin2gray(load_value);
            ModeRing, ModeJohnson: value_d = seed(mode_q, limit, value_q);
            default:               value_d = value_q;
         endcase
      end else if (enabled) begin
         value_d = step(mode_q, limit, value_q);
      end
   end

   always_comb begin
      case (mode_q)
         ModeUp:                          is_term = (value_q >= limit);
         ModeDown:                        is_term = (value_q == '0);
         ModeRing, ModeJohnson, ModeGray: is_term = (value_q == Msb);
         default:                         is_term = 1'b0;
      endcase
   end

   // Reset forces tc low even when value 0 would otherwise be terminal.
   assign tc    = enabled & (mode == mode_q) & ~load & is_term & ~rst;
   assign value = value_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
         mode_q  <= ModeUp;
      end else begin
         value_q <= value_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: tb/tb_multimode_counter.sv
// Randomised and directed bench for multimode_counter with a sequence-index reference model
// and a queue-based scoreboard.
module tb_multimode_counter;

   localparam int W = 4;
   localparam int Mask = (1 << W) - 1;

   logic         clk;
   logic         rst;
   logic         enabled;
   logic [2:0]   mode;
   logic [W-1:0] limit;
   logic         load;
   logic [W-1:0] load_value;
   logic [W-1:0] value;
   logic         tc;

   multimode_counter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enabled   (enabled),
      .mode      (mode),
      .limit     (limit),
      .load      (load),
      .load_value(load_value),
      .value     (value),
      .tc        (tc)
   );

   typedef struct {
      int    v;
      bit    t;
      string tag;
   } exp_t;

   exp_t  sb_q[$];
   int    total = 0;
   int    bad = 0;
   bit    done = 0;
   string phase = "init";

   // Model state: binary modes track the number, sequence modes track the position in the sequence.
   int m_mq  = 0;
   int m_val = 0;
   int m_idx = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cur_value();
      case (m_mq)
         2: return 1 << m_idx;
         3: return (m_idx <= W) ? ((1 << m_idx) - 1) : (Mask & ~((1 << (m_idx - W)) - 1));
         4: return m_idx ^ (m_idx >> 1);
         default: return m_val;
      endcase
   endfunction

   function automatic bit model_tc();
      bit term;
      int lim = int'(limit);
      if (rst || !enabled || load || int'(mode) != m_mq) return 1'b0;
      case (m_mq)
         0: term = (m_val >= lim);
         1: term = (m_val == 0);
         2: term = (m_idx == W - 1);
         3: term = (m_idx == 2 * W - 1);
         4: term = (m_idx == (1 << W) - 1);
         default: term = 1'b0;
      endcase
      return term;
   endfunction

   task automatic model_update();
      int md  = int'(mode);
      int lim = int'(limit);
      m_val = cur_value();
      if (md != m_mq) begin
         m_mq = md;
         case (md)
            0: m_val = 0;
            1: m_val = lim;
            2, 3, 4: m_idx = 0;
            default: ;
         endcase
      end else if (load) begin
         case (m_mq)
            0, 1: m_val = int'(load_value);
            2, 3: m_idx = 0;
            4: m_idx = int'(load_value);
            default: ;
         endcase
      end else if (enabled) begin
         case (m_mq)
            0: m_val = (m_val >= lim) ? 0 : m_val + 1;
            1: m_val = (m_val == 0 || m_val > lim) ? lim : m_val - 1;
            2: m_idx = (m_idx + 1) % W;
            3: m_idx = (m_idx + 1) % (2 * W);
            4: m_idx = (m_idx + 1) % (1 << W);
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input bit r, input bit e, input int md, input int lim, input bit ld,
                      input int lv);
      exp_t x;
      @(negedge clk);
      rst        = r;
      enabled    = e;
      mode       = 3'(md);
      limit      = W'(lim);
      load       = ld;
      load_value = W'(lv);
      #1;
      x.tag = phase;
      if (r) begin
         m_mq  = 0;
         m_val = 0;
         m_idx = 0;
         x.v   = 0;
         x.t   = 1'b0;
      end else begin
         x.v = cur_value();
         x.t = model_tc();
         model_update();
      end
      sb_q.push_back(x);
   endtask

   task automatic run(input int n, input int md, input int lim);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, md, lim, 1'b0, 0);
   endtask

   // Monitor: compares the DUT against the oldest expectation every cycle, mid-phase.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #3;
         if (done) break;
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got value=%0d, required an expectation entry", value);
         end else begin
            x = sb_q.pop_front();
            if (int'(value) != x.v) begin
               bad++;
               $display("FAIL %s value: got %0d required %0d", x.tag, value, x.v);
            end
            total++;
            if (tc !== x.t) begin
               bad++;
               $display("FAIL %s tc: got %0b required %0b", x.tag, tc, x.t);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int md, lim;
      rst = 1'b0; enabled = 1'b0; mode = '0; limit = '0; load = 1'b0; load_value = '0;
      #1 rst = 1'b1;

      phase = "reset_idle";
      cyc(1'b1, 1'b0, 0, 15, 1'b0, 0);
      cyc(1'b1, 1'b0, 0, 15, 1'b0, 0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 0, 15, 1'b0, 0);

      phase = "up_lim9";
      cyc(1'b1, 1'b0, 0, 9, 1'b0, 0);
      run(13, 0, 9);

      phase = "down_lim5";
      run(8, 1, 5);
      cyc(1'b0, 1'b1, 1, 5, 1'b1, 12);
      run(3, 1, 5);

      phase = "ring";
      cyc(1'b1, 1'b0, 2, 0, 1'b0, 0);
      run(7, 2, 0);
      phase = "johnson";
      run(11, 3, 0);
      phase = "gray";
      run(18, 4, 0);
      cyc(1'b0, 1'b1, 4, 0, 1'b1, 5);
      run(3, 4, 0);

      phase = "switch_0_to_2";
      cyc(1'b1, 1'b0, 0, 9, 1'b0, 0);
      run(8, 0, 9);
      run(3, 2, 9);

      phase = "rst_mid_count";
      run(6, 0, 12);
      cyc(1'b1, 1'b1, 0, 12, 1'b0, 0);
      run(3, 0, 12);

      phase = "reserved_hold";
      run(4, 6, 12);

      phase = "limit_zero";
      run(4, 0, 0);
      run(4, 1, 0);
      run(3, 1, 7);

      phase = "random";
      md = 0;
      lim = 9;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(9) == 0) md = $urandom_range(7);
         if ($urandom_range(15) == 0) lim = $urandom_range(15);
         cyc($urandom_range(99) == 0, $urandom_range(4) != 0, md, lim,
             $urandom_range(9) == 0, $urandom_range(15));
      end

      @(negedge clk);
      #2 done = 1'b1;
      #5;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multimode_counter.md
# multimode_counter

Parametrised, free-running sequence counter with a run-time selectable counting mode: binary up, binary down, one-hot ring, Johnson or Gray. It is the next generation of the fixed 4-bit binary and ring counters, for use as a general-purpose sequencer and timebase in lab designs. A terminal-count flag marks the last state of each sequence so that counters can be cascaded. A synchronous load restarts the sequence from a chosen point.

## Interface
- WIDTH, 4, counter width in bits; legal range is WIDTH >= 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enabled  in  1  advances the counter one step per clock while high.
- mode  in  3  sequence select: 0 binary up, 1 binary down, 2 ring, 3 Johnson, 4 Gray, 5..7 reserved.
- limit  in  WIDTH  terminal value for modes 0/1; ignored in other modes.
- load  in  1  synchronous load or restart strobe.
- load_value  in  WIDTH  value to load; binary-coded in modes 0/1/4.
- value  out  WIDTH  registered counter state.
- tc  out  1  combinational terminal-count flag.

## Operation
- Internal state is `value` plus `mode_q`, a registered copy of the last applied mode.
- Seed values per mode:
  - Modes 0, 3 and 4 seed to 0.
  - Mode 1 seeds to `limit`.
  - Mode 2 seeds to 1 (bit 0 set).
- Next-state priority per clock, highest first:
  1. `mode` != `mode_q`: value <= seed(mode) and mode_q <= mode. This happens regardless of `load` and `enabled`.
  2. `load`: value is set as follows.
     - Modes 0/1: value <= load_value.
     - Mode 4: value <= load_value ^ (load_value >> 1).
     - Modes 2/3: value <= seed(mode), and load_value is ignored.
  3. `enabled`: value <= step(mode, value).
  4. Otherwise value holds.
- Step function per mode:
  - Mode 0: value >= limit gives 0; otherwise value + 1.
  - Mode 1: value == 0 or value > limit gives limit; otherwise value - 1.
  - Mode 2: rotate left, {value[WIDTH-2:0], value[WIDTH-1]}. The period is WIDTH.
  - Mode 3: {value[WIDTH-2:0], ~value[WIDTH-1]}. The period is 2*WIDTH.
  - Mode 4: bin2gray(gray2bin(value) + 1), modulo 2^WIDTH. The period is 2^WIDTH.
  - Modes 5..7: hold.
- `tc` is high only when all of the following are true: `enabled` is high, `mode` == `mode_q`, `load` is low, and value is the terminal state of the current mode. Terminal states:
  - Mode 0: value >= limit.
  - Mode 1: value == 0.
  - Mode 2: value == 1 << (WIDTH-1).
  - Modes 3 and 4: value == 1 << (WIDTH-1).
  - Modes 5..7: never.
- `tc` is high exactly in the cycle whose following edge wraps the sequence back to its seed.
- Boundary cases:
  - limit == 0 in mode 0 or 1: value stays 0 and tc is high on every enabled cycle.
  - A change to limit applies on the next step; no reseed occurs.
  - A change of mode in the same cycle as `load` or `enabled`: the mode change wins.
- Mode 2 does not self-correct. A corrupted ring state circulates until the next load or mode change.

## Timing
- Reset: assertion acts immediately and asynchronously.
  - While reset is asserted: value = 0, mode_q = 0, tc = 0 (value 0 is not terminal in mode 0 unless limit == 0).
  - Deassertion is synchronised externally.
  - After release with mode != 0, the first edge performs the reseed. In mode 2 the first edge yields value = 1, not a step from 0.
- Step, load and reseed each have 1-cycle latency from the sampling edge to `value`.
- `tc` is combinational from value, mode, enabled and load. It adds no register delay.
- A reset asserted mid-sequence aborts the sequence at once; there is no partial update.

## Test plan
- WIDTH=4, rst held high then low, mode=0, limit=15, enabled=0 for 10 cycles -> value stays 0 and tc=0 throughout.
- mode=0, limit=9, enabled=1 from reset -> value steps 0,1,...,9,0,1. tc is high only while value=9.
- mode=1, limit=5: the first edge reseeds -> value then runs 5,4,3,2,1,0,5. tc is high only at 0. A load of load_value=12 (> limit) is followed by value=5 on the next step.
- Ring/Johnson check:
  - mode=2 after reset -> value runs 0001,0010,0100,1000,0001, with tc at 1000.
  - mode=3 -> value runs 0000,0001,0011,0111,1111,1110,1100,1000,0000, with tc at 1000.
- Gray check, mode=4 -> value runs 0000,0001,0011,0010,0110,... through 1000, then 0000. Every transition changes exactly one bit. load with load_value=5 gives value=0111.
- Mid-run events:
  - Mode switch 0->2 while value=7 -> next value=0001.
  - rst pulse mid-count -> value=0 immediately, without waiting for a clock edge.
  - mode=6 -> value holds and tc=0.
